dmem_arbiter: RTL
=================

# dmem_arbiter

Two-port arbiter that shares the single-ported, synchronous-read data memory between the core's load/store port and the debug/host read-write port. Fixed priority goes to the core, with a starvation guard that guarantees the debug port forward progress. The block sits between the core datapath, the debug port and the data memory array. It tracks outstanding reads so each response returns to the requester that issued it, and it keeps a saturating contention counter for performance monitoring.

## Interface
- XLEN, 32: data and byte-address width
- ADDR_W, 10: memory word-address width (1024 words)
- STARVE_MAX, 4: contended cycles the debug port may lose before it is forced a grant; legal range 1..15
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- c_req  in  1  core request
- c_we  in  1  core write enable
- c_addr  in  XLEN  core byte address
- c_wdata  in  XLEN  core write data
- c_gnt  out  1  core request accepted this cycle
- c_stall  out  1  c_req & ~c_gnt; freezes the core PC and register write
- c_rvalid  out  1  core read data valid
- c_rdata  out  XLEN  core read data
- d_req, d_we, d_addr, d_wdata, d_gnt, d_rvalid, d_rdata: debug port, same directions, widths and meanings as the c_ port
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory word address
- mem_wdata  out  XLEN  memory write data
- mem_rdata  in  XLEN  memory read data, valid the cycle after a read strobe
- conflict_cnt  out  16  saturating count of cycles in which both ports requested

## Operation
- Word address is addr[ADDR_W+1:2]. Bits [1:0] are ignored; all accesses are full-word.
- At most one grant per cycle. Grants are combinational from req in the same cycle.
- Requesters hold req, we, addr and wdata stable until the cycle in which gnt is high. Dropping req before grant is legal and cancels the request.
- Arbitration:
  - Only one port requests: that port is granted.
  - Both request and starve_cnt < STARVE_MAX: the core is granted.
  - Both request and starve_cnt == STARVE_MAX: debug is granted and the core stalls.
- starve_cnt, 4-bit internal:
  - Increments when d_req & ~d_gnt, saturating at STARVE_MAX.
  - Clears when d_gnt is high.
  - Holds otherwise.
- Memory side:
  - mem_en = c_gnt | d_gnt.
  - mem_we, mem_addr and mem_wdata are muxed from the granted port.
  - When idle, mem_we = 0 and mem_addr and mem_wdata = 0.
- Response tracker, registered:
  - rd_pend is set on a granted read; rd_owner records the port (0 = core, 1 = debug).
  - The next cycle, the owner's rvalid = rd_pend and its rdata = mem_rdata.
  - The non-owner's rvalid = 0 and rdata = 0.
  - Writes produce no response.
- conflict_cnt increments on every cycle with c_req & d_req, regardless of outcome, and saturates at 0xFFFF.

## Timing
- Reset values, held while reset is high:
  - All gnt outputs 0, c_stall 0, mem_en 0, mem_we 0.
  - c_rvalid and d_rvalid 0; c_rdata and d_rdata 0.
  - conflict_cnt 0, starve_cnt 0, rd_pend 0.
- Read latency is 1 cycle: granted in cycle T, rvalid and rdata in T+1.
- Write takes effect at the clock edge ending cycle T.
- Back-to-back grants every cycle are supported, with either port in any order. A response in T+1 coexists with a new grant in T+1.
- Read-after-write to the same address in consecutive cycles returns the new data. This relies on the memory's write-then-read ordering and is not forwarded by this block.
- Reset asserted mid-operation: a pending response is dropped and rvalid falls asynchronously. No spurious rvalid appears after reset releases.
- The only grant-gating sequential state is starve_cnt; there is no combinational loop from rdata to gnt.

## Test plan
- Core-only read:
  - Stimulus: memory preloaded with word 4 = 0xDEADBEEF; c_req = 1, c_we = 0, c_addr = 0x10.
  - Required: c_gnt = 1 the same cycle with mem_addr = 4. Next cycle c_rvalid = 1, c_rdata = 0xDEADBEEF, d_rvalid = 0.
- Debug write while the core is idle:
  - Stimulus: d_we = 1, d_addr = 0x20, d_wdata = 0x12345678.
  - Required: d_gnt = 1, mem_we = 1, mem_addr = 8; no d_rvalid. A later core read of 0x20 returns 0x12345678.
- Sustained contention with STARVE_MAX = 4, both ports reading continuously for 10 cycles:
  - Core granted in cycles 0–3, debug in cycle 4, core in 5–8, debug in 9.
  - c_stall is high in cycles 4 and 9; conflict_cnt = 10.
- Interleaved reads:
  - Stimulus: core reads addr 0x0 (word 0 = 0xA), then debug reads addr 0x4 (word 1 = 0xB) the next cycle.
  - Required: c_rvalid with 0xA, then d_rvalid with 0xB; no cross-delivery.
- Reset mid-read:
  - Stimulus: core read granted, then reset asserted in the following cycle.
  - Required: c_rvalid = 0 immediately, all outputs at reset values; after release, no rvalid until a new grant.
- conflict_cnt saturation:
  - Stimulus: force 65 540 contended cycles.
  - Required: conflict_cnt stops at 0xFFFF and does not wrap.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Shares the single-ported synchronous-read data memory between the core load/store port and
// the debug port. The core has fixed priority, and a starvation guard forces a debug grant.
module dmem_arbiter #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  // core port
  input  logic              i_c_req,
  input  logic              i_c_we,
  input  logic [XLEN-1:0]   i_c_addr,
  input  logic [XLEN-1:0]   i_c_wdata,
  output logic              o_c_gnt,
  output logic              o_c_stall,
  output logic              o_c_rvalid,
  output logic [XLEN-1:0]   o_c_rdata,
  // debug port
  input  logic              i_d_req,
  input  logic              i_d_we,
  input  logic [XLEN-1:0]   i_d_addr,
  input  logic [XLEN-1:0]   i_d_wdata,
  output logic              o_d_gnt,
  output logic              o_d_rvalid,
  output logic [XLEN-1:0]   o_d_rdata,
  // memory side
  output logic              o_mem_en,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [XLEN-1:0]   o_mem_wdata,
  input  logic [XLEN-1:0]   i_mem_rdata,
  // performance monitor
  output logic [15:0]       o_conflict_cnt
);

  localparam logic [3:0]  STARVE_LIM = 4'(STARVE_MAX);
  localparam logic [15:0] CNT_MAX    = 16'hFFFF;

  logic [3:0]  r_starve_cnt;
  logic [15:0] r_conflict_cnt;
  logic        r_rd_pend;
  logic        r_rd_owner;

  logic              w_both;
  logic              w_force_dbg;
  logic              w_c_gnt;
  logic              w_d_gnt;
  logic [ADDR_W-1:0] w_c_word;
  logic [ADDR_W-1:0] w_d_word;
  logic              w_unused_addr;

  assign w_c_word = i_c_addr[ADDR_W+1:2];
  assign w_d_word = i_d_addr[ADDR_W+1:2];

  // Byte offset and bits above the memory range play no part in addressing.
  assign w_unused_addr = ^{i_c_addr[1:0], i_c_addr[XLEN-1:ADDR_W+2],
                           i_d_addr[1:0], i_d_addr[XLEN-1:ADDR_W+2]};

  // Grant logic: depends only on the request inputs and r_starve_cnt.
  always_comb begin
    w_both      = i_c_req & i_d_req;
    w_force_dbg = w_both & (r_starve_cnt == STARVE_LIM);
    w_c_gnt     = ~reset & i_c_req & ~w_force_dbg;
    w_d_gnt     = ~reset & i_d_req & (~i_c_req | w_force_dbg);
  end

  assign o_c_gnt   = w_c_gnt;
  assign o_d_gnt   = w_d_gnt;
  assign o_c_stall = ~reset & i_c_req & ~w_c_gnt;

  always_comb begin
    o_mem_en    = w_c_gnt | w_d_gnt;
    o_mem_we    = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    if (w_c_gnt) begin
      o_mem_we    = i_c_we;
      o_mem_addr  = w_c_word;
      o_mem_wdata = i_c_wdata;
    end else if (w_d_gnt) begin
      o_mem_we    = i_d_we;
      o_mem_addr  = w_d_word;
      o_mem_wdata = i_d_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_starve_cnt <= 4'd0;
    end else if (w_d_gnt) begin
      r_starve_cnt <= 4'd0;
    end else if (i_d_req && (r_starve_cnt != STARVE_LIM)) begin
      r_starve_cnt <= r_starve_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_conflict_cnt <= 16'd0;
    end else if (w_both && (r_conflict_cnt != CNT_MAX)) begin
      r_conflict_cnt <= r_conflict_cnt + 16'd1;
    end
  end

  assign o_conflict_cnt = r_conflict_cnt;

  // One outstanding read at most; the owner bit steers the returning word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_pend  <= 1'b0;
      r_rd_owner <= 1'b0;
    end else begin
      r_rd_pend  <= (w_c_gnt & ~i_c_we) | (w_d_gnt & ~i_d_we);
      r_rd_owner <= w_d_gnt;
    end
  end

  always_comb begin
    o_c_rvalid = r_rd_pend & ~r_rd_owner;
    o_d_rvalid = r_rd_pend & r_rd_owner;
    o_c_rdata  = o_c_rvalid ? i_mem_rdata : '0;
    o_d_rdata  = o_d_rvalid ? i_mem_rdata : '0;
  end

endmodule
